// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-128 CTR stream engine: FSM states, round
// constants, block/key widths and elaboration-time parameter checks.
package aes_ctr_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        KS    = 2'd2,
        OUT   = 2'd3
    } ctr_state_e;

    // Indexed directly by round number (1..10); the padding keeps any 4-bit index in range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic bit unroll_legal(input int u);
        return (u == 1) || (u == 2) || (u == 5);
    endfunction

    function automatic bit ctr_w_legal(input int w);
        return (w >= 8) && (w <= 64);
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round with on-the-fly key expansion:
// derives round key r from key r-1 and applies it to the transformed state.
module aes_round_unit
    import aes_ctr_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_i,
    input  logic [AES_KEY_W-1:0] rkey_i,
    input  logic [3:0]           round_i,
    input  logic                 final_i,
    output logic [AES_BLK_W-1:0] state_o,
    output logic [AES_KEY_W-1:0] rkey_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]           sb [16];
    logic [7:0]           sr [16];
    logic [7:0]           mc [16];
    logic [AES_BLK_W-1:0] sr_w;
    logic [AES_BLK_W-1:0] mc_w;
    logic [31:0]          rot_w;
    logic [31:0]          tmp_w;
    logic [31:0]          n0, n1, n2, n3;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_i[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            sr_w[127-8*i -: 8] = sr[i];
            mc_w[127-8*i -: 8] = mc[i];
        end
    end

    always_comb begin
        rot_w = {rkey_i[23:0], rkey_i[31:24]};
        tmp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
                ^ {RCON[round_i], 24'h000000};
        n0 = rkey_i[127:96] ^ tmp_w;
        n1 = rkey_i[95:64]  ^ n0;
        n2 = rkey_i[63:32]  ^ n1;
        n3 = rkey_i[31:0]   ^ n2;
    end

    assign rkey_o  = {n0, n1, n2, n3};
    // The last round skips MixColumns.
    assign state_o = (final_i ? sr_w : mc_w) ^ rkey_o;

endmodule

// File: rtl/aes_ctr_stream.sv
// AES-128 counter-mode stream engine: one 128-bit block in, keystream-XORed
// block out, UNROLL rounds per clock, counter advanced on each output handshake.
module aes_ctr_stream
    import aes_ctr_pkg::*;
#(
    parameter int CTR_W  = 32,
    parameter int UNROLL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [AES_KEY_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 ctr_wrap
);

    if (!unroll_legal(UNROLL) || !ctr_w_legal(CTR_W)) begin : g_param_check
        $error("aes_ctr_stream: CTR_W must be 8..64 and UNROLL one of 1, 2, 5");
    end

    ctr_state_e           state_q, state_d;
    logic [AES_KEY_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] ctr_q, ctr_d;
    logic [AES_BLK_W-1:0] din_q, din_d;
    logic [AES_BLK_W-1:0] st_q, st_d;
    logic [AES_KEY_W-1:0] rk_q, rk_d;
    logic [AES_BLK_W-1:0] dout_q, dout_d;
    logic [3:0]           rnd_q, rnd_d;
    logic                 last_q, last_d;
    logic                 wrap_q, wrap_d;

    logic                 cfg_fire, in_fire, out_fire;
    logic [AES_BLK_W-1:0] ks_st;
    logic [AES_KEY_W-1:0] ks_rk;
    logic                 ks_done;
    logic [CTR_W-1:0]     ctr_lo_inc;
    logic [AES_BLK_W-1:0] ctr_inc;

    // Round chain: unit g handles round rnd_q + g within the current cycle.
    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        logic [AES_BLK_W-1:0] st_i, st_o;
        logic [AES_KEY_W-1:0] rk_i, rk_o;
        logic [3:0]           idx;
        if (g == 0) begin : g_first
            assign st_i = st_q;
            assign rk_i = rk_q;
        end else begin : g_next
            assign st_i = g_rnd[g-1].st_o;
            assign rk_i = g_rnd[g-1].rk_o;
        end
        assign idx = rnd_q + 4'(g);
        aes_round_unit u_round (
            .state_i (st_i),
            .rkey_i  (rk_i),
            .round_i (idx),
            .final_i (idx == 4'(AES_NR)),
            .state_o (st_o),
            .rkey_o  (rk_o)
        );
    end

    assign ks_st   = g_rnd[UNROLL-1].st_o;
    assign ks_rk   = g_rnd[UNROLL-1].rk_o;
    assign ks_done = (g_rnd[UNROLL-1].idx == 4'(AES_NR));

    // Only the low CTR_W bits count; the nonce above them never changes.
    assign ctr_lo_inc = ctr_q[CTR_W-1:0] + CTR_W'(1);
    if (CTR_W < AES_BLK_W) begin : g_ctr_split
        assign ctr_inc = {ctr_q[AES_BLK_W-1:CTR_W], ctr_lo_inc};
    end else begin : g_ctr_full
        assign ctr_inc = ctr_lo_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_d = READY;
            end
            READY: begin
                in_ready = 1'b1;
                if (in_valid) state_d = KS;
            end
            KS: begin
                if (ks_done) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = last_q ? IDLE : READY;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_fire = cfg_ready & cfg_valid;
    assign in_fire  = in_ready & in_valid;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        key_d  = key_q;
        ctr_d  = ctr_q;
        din_d  = din_q;
        last_d = last_q;
        st_d   = st_q;
        rk_d   = rk_q;
        rnd_d  = rnd_q;
        dout_d = dout_q;
        wrap_d = wrap_q;
        if (cfg_fire) begin
            key_d  = cfg_key;
            ctr_d  = cfg_iv;
            wrap_d = 1'b0;
        end
        if (in_fire) begin
            din_d  = in_data;
            last_d = in_last;
            st_d   = ctr_q ^ key_q;
            rk_d   = key_q;
            rnd_d  = 4'd1;
        end
        if (state_q == KS) begin
            st_d  = ks_st;
            rk_d  = ks_rk;
            rnd_d = rnd_q + 4'(UNROLL);
            if (ks_done) dout_d = ks_st ^ din_q;
        end
        if (out_fire) begin
            ctr_d = ctr_inc;
            if (ctr_lo_inc == '0) wrap_d = 1'b1;
        end
    end

    // Reset also scrubs key material and any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            ctr_q  <= '0;
            din_q  <= '0;
            last_q <= 1'b0;
            st_q   <= '0;
            rk_q   <= '0;
            rnd_q  <= '0;
            dout_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            key_q  <= key_d;
            ctr_q  <= ctr_d;
            din_q  <= din_d;
            last_q <= last_d;
            st_q   <= st_d;
            rk_q   <= rk_d;
            rnd_q  <= rnd_d;
            dout_q <= dout_d;
            wrap_q <= wrap_d;
        end
    end

    assign out_data = dout_q;
    assign out_last = last_q;
    assign ctr_wrap = wrap_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream: four instances (default, UNROLL=2, UNROLL=5,
// CTR_W=8) share inputs; outputs are checked against published AES vectors.
module tb_aes_ctr_stream;

    logic         clk = 1'b0;
    logic         rst, cfg_valid, in_valid, in_last, out_ready;
    logic [127:0] cfg_key, cfg_iv, in_data;
    logic [3:0]   cr, ir, ov, ol, bz, wr;
    logic [127:0] od [4];

    int           n_chk = 0;
    int           n_err = 0;
    int           lat_r [4];
    logic [127:0] dat_r [4];
    logic         lst_r [4];
    int           exp_lat [4];
    logic         seen;

    typedef struct {
        logic         do_cfg;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
        logic         last;
        logic [127:0] exp;
        logic         wrap8;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    aes_ctr_stream u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_ready(cr[0]), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
        .out_ready(out_ready), .busy(bz[0]), .ctr_wrap(wr[0]));

    aes_ctr_stream #(.UNROLL(2)) u_un2 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_ready(cr[1]), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
        .out_ready(out_ready), .busy(bz[1]), .ctr_wrap(wr[1]));

    aes_ctr_stream #(.UNROLL(5)) u_un5 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_ready(cr[2]), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]),
        .out_ready(out_ready), .busy(bz[2]), .ctr_wrap(wr[2]));

    aes_ctr_stream #(.CTR_W(8)) u_ctr8 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_ready(cr[3]), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od[3]), .out_last(ol[3]),
        .out_ready(out_ready), .busy(bz[3]), .ctr_wrap(wr[3]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic with_in);
        @(negedge clk);
        chk("cfg_ready_all", {124'd0, cr}, 128'hf);
        cfg_valid = 1'b1;
        cfg_key   = k;
        cfg_iv    = iv;
        in_valid  = with_in;
        in_data   = '0;
        in_last   = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Handshake one block, then record per-DUT latency (edges after the handshake edge).
    task automatic run_block(input logic [127:0] din, input logic last);
        @(negedge clk);
        chk("in_ready_all", {124'd0, ir}, 128'hf);
        in_valid = 1'b1;
        in_data  = din;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            lat_r[d] = -1;
            dat_r[d] = '0;
            lst_r[d] = 1'b0;
        end
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && lat_r[d] < 0) begin
                    lat_r[d] = e;
                    dat_r[d] = od[d];
                    lst_r[d] = ol[d];
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_lat = '{10, 5, 2, 10};
        tbl[0] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h0, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1};
        tbl[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h0, 1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
        tbl[2] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                   128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'h874d6191b620e3261bef6864990db6ce, 1'b1};
        tbl[3] = '{1'b0, 128'h0, 128'h0,
                   128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 128'h9806f66b7970fdff8617187bb9fffdff, 1'b1};

        rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        cfg_key = '0; cfg_iv = '0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_ctl_dut%0d", d), {122'd0, cr[d], ir[d], ov[d], ol[d], bz[d], wr[d]}, 128'b100000);
            chk($sformatf("reset_data_dut%0d", d), od[d], 128'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (tbl[i].do_cfg) do_cfg(tbl[i].key, tbl[i].iv, 1'b0);
            run_block(tbl[i].din, tbl[i].last);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("v%0d_data_dut%0d", i, d), dat_r[d], tbl[i].exp);
            end
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("v%0d_latency_dut%0d", i, d), 128'(lat_r[d]), 128'(exp_lat[d]));
            end
            if (tbl[i].do_cfg) chk($sformatf("v%0d_data_ctr8", i), dat_r[3], tbl[i].exp);
            chk($sformatf("v%0d_out_last", i), {127'd0, lst_r[0]}, {127'd0, tbl[i].last});
            chk($sformatf("v%0d_wrap_dut0", i), {127'd0, wr[0]}, 128'h0);
            chk($sformatf("v%0d_wrap_ctr8", i), {127'd0, wr[3]}, {127'd0, tbl[i].wrap8});
            chk($sformatf("v%0d_busy_after", i), {127'd0, bz[0]}, {127'd0, ~tbl[i].last});
        end

        // 8-bit counter wrap: iv ..00ff, second block runs on the all-zero counter block.
        do_cfg(128'h0, 128'h00000000000000000000000000000000ff, 1'b1);
        @(negedge clk);
        chk("cfg_beats_in_ready", {126'd0, ir[0], bz[0]}, 128'b11);
        chk("cfg_clears_wrap", {127'd0, wr[3]}, 128'h0);
        run_block(128'h0, 1'b0);
        chk("wrap8_after_first", {127'd0, wr[3]}, 128'h1);
        chk("wrap32_after_first", {127'd0, wr[0]}, 128'h0);
        run_block(128'h0, 1'b1);
        chk("wrap8_zero_counter_data", dat_r[3], 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        chk("wrap8_latency", 128'(lat_r[3]), 128'd10);
        chk("wrap8_out_last", {127'd0, lst_r[3]}, 128'h1);

        // Backpressure hold, then reset while a block is in flight.
        do_cfg(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_last   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 20 && !seen; e++) begin
            @(negedge clk);
            seen = ov[0];
        end
        chk("hold_valid_seen", {127'd0, seen}, 128'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", c), {127'd0, ov[0]}, 128'h1);
            chk($sformatf("hold%0d_data", c), od[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            chk($sformatf("hold%0d_in_ready", c), {127'd0, ir[0]}, 128'h0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_to_ready", {126'd0, ov[0], ir[0]}, 128'b01);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ks_before_rst", {126'd0, bz[0], ov[0]}, 128'b10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ks_ctl", {122'd0, cr[0], ir[0], ov[0], ol[0], bz[0], wr[0]}, 128'b100000);
        chk("rst_in_ks_data", od[0], 128'h0);
        seen = 1'b0;
        for (int e = 0; e < 15; e++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        chk("rst_discards_block", {127'd0, seen}, 128'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
